// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU control sequencer: FSM states,
// instruction field positions and the default program counter width.
package hack_pkg;

    localparam int HACK_PC_W = 15;

    localparam int CI_BIT  = 15;
    localparam int A_BIT   = 12;
    localparam int ALU_LSB = 6;
    localparam int DEST_A  = 5;
    localparam int DEST_D  = 4;
    localparam int DEST_M  = 3;
    localparam int JMP_LSB = 0;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        MREAD,
        EXEC,
        MWRITE,
        HALT
    } state_t;

endpackage

// File: rtl/hack_jump_eval.sv
// Hack jump condition: j[2] selects negative, j[1] zero, j[0] strictly positive.
module hack_jump_eval (
    input  logic [2:0] j,
    input  logic       zero,
    input  logic       neg,
    output logic       take
);

    assign take = (j[2] & neg) | (j[1] & zero) | (j[0] & ~neg & ~zero);

endmodule

// File: rtl/hack_cpu_control.sv
// Multi-cycle Hack CPU control sequencer: fetch/decode, A/D/PC ownership,
// ALU control, M read/write and jumps. Optional HACK_HALT_DETECT_EN stops on a self-loop jump.
module hack_cpu_control
    import hack_pkg::*;
#(
    parameter int PC_W   = HACK_PC_W,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_data,
    output logic              dmem_rd_req,
    output logic              dmem_wr_req,
    output logic [14:0]       dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic              zerox,
    output logic              negx,
    output logic              zeroy,
    output logic              negy,
    output logic              functioncode,
    output logic              neg_out,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    input  logic              alu_neg,
    output logic              halted
);

    state_t              state_reg, state_next;
    logic [PC_W-1:0]     pc_reg;
    logic [DATA_W-1:0]   a_reg, d_reg, ir_reg, m_reg, result_reg, old_a_reg;
    logic [5:0]          alu_ctl;
    logic                take;
    logic                unused_bits;

    assign unused_bits = old_a_reg[DATA_W-1];

    hack_jump_eval u_jump_eval (
        .j    (ir_reg[JMP_LSB +: 3]),
        .zero (alu_zero),
        .neg  (alu_neg),
        .take (take)
    );

`ifdef HACK_HALT_DETECT_EN
    logic halt_pend_reg;
    logic self_loop;
    // An unconditional jump to its own address can never leave, so park there.
    assign self_loop = take && (ir_reg[JMP_LSB +: 3] == 3'b111) &&
                       (old_a_reg[PC_W-1:0] == pc_reg);
`endif

    assign imem_addr  = pc_reg;
    assign dmem_wdata = result_reg;
    assign alu_x      = d_reg;
    assign alu_y      = ir_reg[A_BIT] ? m_reg : a_reg;
    assign {zerox, negx, zeroy, negy, functioncode, neg_out} = alu_ctl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Requests are masked while reset is held so nothing leaks out mid-reset.
    always_comb begin
        state_next  = state_reg;
        imem_req    = 1'b0;
        dmem_rd_req = 1'b0;
        dmem_wr_req = 1'b0;
        dmem_addr   = a_reg[14:0];
        alu_ctl     = 6'b0;
        halted      = 1'b0;
        if (!reset) begin
            case (state_reg)
                FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) state_next = DECODE;
                end
                DECODE: begin
                    if (!ir_reg[CI_BIT])     state_next = FETCH;
                    else if (ir_reg[A_BIT])  state_next = MREAD;
                    else                     state_next = EXEC;
                end
                MREAD: begin
                    dmem_rd_req = 1'b1;
                    if (dmem_ack) state_next = EXEC;
                end
                EXEC: begin
                    alu_ctl    = ir_reg[ALU_LSB +: 6];
                    state_next = ir_reg[DEST_M] ? MWRITE : FETCH;
`ifdef HACK_HALT_DETECT_EN
                    if (!ir_reg[DEST_M] && self_loop) state_next = HALT;
`endif
                end
                MWRITE: begin
                    dmem_wr_req = 1'b1;
                    dmem_addr   = old_a_reg[14:0];
                    if (dmem_ack) begin
`ifdef HACK_HALT_DETECT_EN
                        state_next = halt_pend_reg ? HALT : FETCH;
`else
                        state_next = FETCH;
`endif
                    end
                end
`ifdef HACK_HALT_DETECT_EN
                HALT: begin
                    halted = 1'b1;
                end
`endif
                default: state_next = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg     <= '0;
            a_reg      <= '0;
            d_reg      <= '0;
            ir_reg     <= '0;
            m_reg      <= '0;
            result_reg <= '0;
            old_a_reg  <= '0;
`ifdef HACK_HALT_DETECT_EN
            halt_pend_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                FETCH: if (imem_ack) ir_reg <= imem_data;
                DECODE: begin
                    if (!ir_reg[CI_BIT]) begin
                        a_reg  <= {1'b0, ir_reg[DATA_W-2:0]};
                        pc_reg <= pc_reg + 1'b1;
                    end else begin
                        old_a_reg <= a_reg;
                    end
                end
                MREAD: if (dmem_ack) m_reg <= dmem_rdata;
                EXEC: begin
                    result_reg <= alu_out;
                    if (ir_reg[DEST_A]) a_reg <= alu_out;
                    if (ir_reg[DEST_D]) d_reg <= alu_out;
                    // Jump target comes from A as it was before this instruction wrote it.
                    pc_reg <= take ? old_a_reg[PC_W-1:0] : pc_reg + 1'b1;
`ifdef HACK_HALT_DETECT_EN
                    halt_pend_reg <= self_loop;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/hack_cpu_control.md
Name: hack_cpu_control

Overview:
Multi-cycle control sequencer that drives the Hack ALU and consumes its result and flags. It fetches 16-bit Hack instructions over a req/ack instruction port and decodes them. It owns the A, D and PC registers, issues the six ALU control bits, reads M when needed, writes results back, and evaluates jumps from the ALU zero/negative flags. It sits between instruction ROM, data RAM and the ALU inside the CPU top.

Parameters:
PC_W, 15, program counter and ROM address width
DATA_W, 16, data/instruction width; fixed at 16 for Hack encoding

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch address (= PC)
imem_ack  in  1  instruction valid this cycle
imem_data  in  16  fetched instruction
dmem_rd_req  out  1  data read request (M operand)
dmem_wr_req  out  1  data write request (dest M)
dmem_addr  out  15  data address (= A[14:0])
dmem_wdata  out  16  write data (captured ALU result)
dmem_ack  in  1  completes the current read or write
dmem_rdata  in  16  read data, valid with dmem_ack on a read
alu_x  out  16  ALU x operand (= D)
alu_y  out  16  ALU y operand (A, or latched M when a=1)
zerox, negx, zeroy, negy, functioncode, neg_out  out  1 each  ALU controls from instr[11:6]
alu_out  in  16  ALU result
alu_zero, alu_neg  in  1 each  ALU flags
halted  out  1  halt-detect status (optional feature; tied 0 otherwise)

Behaviour:
- Reset (synchronous): PC=0; A=0; D=0; IR=0; M latch=0; state=FETCH. All req outputs, ALU controls and halted are 0. Reset wins over any in-flight handshake; req drops on the reset edge and any late ack is ignored.
- Handshake: a req stays high with address/data stable until ack is sampled high. The transfer completes on that edge, and req is low in the next state. Ack is ignored while req is low. Read and write req are never high together.
- States:
  - FETCH: imem_req=1. On imem_ack, IR<=imem_data and go to DECODE.
  - DECODE, instr[15]=0 (A-instruction): A<={1'b0,IR[14:0]}, PC<=PC+1 (wraps modulo 2^PC_W), go to FETCH.
  - DECODE, instr[15]=1 (C-instruction): if a=IR[12]=1 go to MREAD, else go to EXEC.
  - MREAD: dmem_rd_req=1, dmem_addr=A[14:0]. On ack, latch dmem_rdata and go to EXEC.
  - EXEC: ALU controls = IR[11:6]; alu_x=D; alu_y = a ? Mlatch : A.
    - Capture alu_out into the result register.
    - Evaluate jump from IR[2:0]: take = (j2&neg) | (j1&zero) | (j0&~neg&~zero).
    - If dest A (IR[5]): A<=alu_out. If dest D (IR[4]): D<=alu_out.
    - Jump target and M address use the pre-instruction A value, latched on DECODE exit.
    - PC<= take ? oldA[14:0] : PC+1.
    - Go to MWRITE if dest M (IR[3]), else FETCH.
  - MWRITE: dmem_wr_req=1, dmem_addr=oldA[14:0], dmem_wdata=result. On ack, go to FETCH.
- ALU controls are driven only in EXEC and are 0 in all other states.
- IR[14:13] are don't-care.
- Minimum latency: A-instruction 2 cycles; C-instruction 3 cycles plus 1 per memory access, plus any ack wait.
- Dest "AMD" with jump: A, D and M all update, M goes to the old A address, and the jump uses old A.

Optional Feature:
HACK_HALT_DETECT_EN. When defined, an EXEC with jump taken, unconditional code (IR[2:0]=3'b111) and oldA[14:0]==PC moves to HALT. In HALT, halted=1, no further requests are issued and the FSM stays until reset. A pending MWRITE completes before HALT. When undefined, there is no HALT state, halted is tied 0, and the self-loop executes forever.

Decomposition:
- Shared package hack_pkg:
  - state enum (FETCH, DECODE, MREAD, EXEC, MWRITE, HALT);
  - instruction field positions (CI_BIT=15, A_BIT=12, ALU_LSB=6, DEST_A=5, DEST_D=4, DEST_M=3, JMP_LSB=0);
  - PC_W default.
- One combinational sub-module, hack_jump_eval: inputs j[2:0], zero, neg; output take.

Test Plan:
- Reset mid-fetch with imem_req high and imem_ack delayed -> next cycle imem_req=0, PC=0, A=D=0, and a later ack is ignored.
- @5 (0x0005) then D=A (0xEC10) -> A=5, D=5, PC=2; ALU controls seen in EXEC = 110000.
- @7; D=A; @3; D=D+A (0xE090) -> D=10 and no dmem traffic.
- @100; M=D+1 (0xE7C8) with D=0xFFFF -> dmem_wr_req with addr=100, wdata=0, and the write holds until dmem_ack.
- @20; D;JEQ (0xE302) with D=0 -> PC=20; same instruction with D=1 -> PC increments.
- With HACK_HALT_DETECT_EN: @4 at PC=3, then 0;JMP at PC=4 -> halted=1 and no further imem_req. Without the macro -> PC=4 repeatedly.
